// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//
// Request-driven drain engine for the read side of a `fifo`. A length request
// is accepted in IDLE. Exactly that many words are then popped from the
// attached fifo and presented on a valid/ready output stream through a
// 2-entry skid buffer. The final word of the request is flagged with
// out_last. A one-cycle `done` pulse follows the handshake of that word, or
// follows the acceptance of a zero-length request.
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous, active-low reset
//   fifo_empty  : `empty` from the attached fifo
//   fifo_data   : `data_out` from the attached fifo; valid while !fifo_empty
//   fifo_pop    : `pop` to the attached fifo
//   req_valid   : request strobe
//   req_len     : number of words to read, sampled on the request handshake
//   req_ready   : high only while idle
//   out_valid   : output word valid (skid buffer is not empty)
//   out_ready   : downstream accepts the word
//   out_data    : output word (skid head)
//   out_last    : the output word is the last word of the request
//   done        : one-cycle pulse when the request completes
// ---------------------------------------------------------------------------
module fifo_reader #(
  parameter int WIDTH  = 8,
  parameter int CNTWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_pop,
  input  logic              req_valid,
  input  logic [CNTWID-1:0] req_len,
  output logic              req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNTWID-1:0] pops_left_q, pops_left_d;
  logic              done_q, done_d;

  // Skid buffer: two entries used as a tiny circular FIFO.
  logic [WIDTH-1:0]  skid_data_q [2];
  logic [WIDTH-1:0]  skid_data_d [2];
  logic              skid_last_q [2];
  logic              skid_last_d [2];
  logic              skid_head_q, skid_head_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  logic              req_fire;
  logic              pop;
  logic              out_fire;
  logic              skid_tail;
  logic              last_pop;

  assign req_ready = (state_q == ST_IDLE);
  assign req_fire  = req_valid & req_ready;

  // Popping never looks at out_ready: the second skid entry absorbs the word
  // that is already in flight when the consumer stalls.
  assign pop       = (state_q == ST_READ) & ~fifo_empty & (skid_cnt_q < 2'd2);
  assign fifo_pop  = pop;
  assign last_pop  = (pops_left_q == CNTWID'(1));

  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = skid_data_q[skid_head_q];
  assign out_last  = skid_last_q[skid_head_q];
  assign done      = done_q;

  // With at most two entries the tail is the head when empty and the other
  // slot when one entry is occupied.
  assign skid_tail = skid_head_q ^ skid_cnt_q[0];

  // -------------------------------------------------------------------------
  // Next-state logic for the request FSM
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so that
    // no path leaves it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    pops_left_d = pops_left_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          if (req_len != '0) begin
            state_d     = ST_READ;
            pops_left_d = req_len;
          end else begin
            // Zero-length request completes immediately with no pops.
            done_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (pop) begin
          pops_left_d = pops_left_q - CNTWID'(1);
          if (last_pop) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // The last word can only reach the skid head after READ has been
        // left, so its handshake is only watched here.
        if (out_fire && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic for the skid buffer
  // -------------------------------------------------------------------------
  always_comb begin
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_head_d = skid_head_q;
    skid_cnt_d  = skid_cnt_q;

    if (pop) begin
      skid_data_d[skid_tail] = fifo_data;
      skid_last_d[skid_tail] = last_pop;
    end

    if (out_fire) begin
      skid_head_d = ~skid_head_q;
    end

    // Push and pop in the same cycle leave the occupancy unchanged.
    unique case ({pop, out_fire})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pops_left_q <= '0;
      done_q      <= 1'b0;
      skid_head_q <= 1'b0;
      skid_cnt_q  <= 2'd0;
      // NOTE: the skid storage is reset as well, not only its occupancy,
      // because out_data and out_last are read straight from it and must
      // come out of reset as zero.
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= '0;
        skid_last_q[i] <= 1'b0;
      end
    end else begin
      // NOTE: registers use non-blocking assignments so that every flop
      // samples the pre-edge value of the others; the combinational blocks
      // above use blocking assignments.
      state_q     <= state_d;
      pops_left_q <= pops_left_d;
      done_q      <= done_d;
      skid_head_q <= skid_head_d;
      skid_cnt_q  <= skid_cnt_d;
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= skid_data_d[i];
        skid_last_q[i] <= skid_last_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
//
// Directed bench for fifo_reader. The attached fifo is modelled with a small
// array and read/write pointers. Expected output words are pushed to a
// scoreboard queue when a request is issued. A negedge monitor pops the
// queue on every output handshake and compares. The monitor also checks that
// the output holds steady under back-pressure and that no pop is issued
// while the fifo is empty.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

  localparam int W = 8;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_pop;
  logic         req_valid = 1'b0;
  logic [C-1:0] req_len = '0;
  logic         req_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Fifo model
  logic [W-1:0] fmem [64];
  int           frd     = 0;
  int           fwr     = 0;
  int           pop_cnt = 0;
  logic         flush   = 1'b0;

  // Scoreboard and logs
  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q [$];
  int           hs_log [$];
  int           done_log [$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  fifo_reader #(.WIDTH(W), .CNTWID(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .req_valid  (req_valid),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (frd == fwr);
  assign fifo_data  = fmem[frd[5:0]];

  always @(posedge clk) begin
    if (flush) begin
      frd <= fwr;
    end else if (fifo_pop && (frd != fwr)) begin
      frd     <= frd + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: all DUT outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (fifo_pop) begin
        check("pop_while_empty", 32'(fifo_empty), 0);
      end
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_last", 32'(out_last), 32'(e.last));
        end
      end
      if (done) begin
        done_log.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [W-1:0] d);
    fmem[fwr[5:0]] = d;
    fwr = fwr + 1;
  endtask

  task automatic fifo_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic clear_logs();
    hs_log.delete();
    done_log.delete();
  endtask

  // Must be called just after a rising edge. Returns the cycle number T
  // whose closing edge carried the request handshake.
  task automatic do_req(input int len, output int t);
    int budget;
    budget = 100;
    while (!req_ready && budget > 0) begin
      step();
      budget--;
    end
    check("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_len   = C'(len);
    step();
    t = cyc - 1;
    req_valid = 1'b0;
    req_len   = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int b;
    b = budget;
    while (done_log.size() < target && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check("done_timeout", 32'(done_log.size() >= target), 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int base;
    int b;
    int r;

    // ---------------- Reset state (fifo already holds data) ----------------
    for (int i = 0; i < 5; i++) fifo_push(W'(8'h10 + i));
    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_pop", 32'(fifo_pop), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req_ready", 32'(req_ready), 1);

    // ---------------- Full-rate read of 5 words ----------------
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(W'(8'h10 + i), i == 4);
    rst  = 1'b1;
    base = pop_cnt;
    do_req(5, t);  // accepted at the first edge after reset release
    wait_done(1, 50);
    check("t1_hs_count", 32'(hs_log.size()), 5);
    check("t1_first_hs", 32'(hs_log[0]), 32'(t + 2));
    check("t1_last_hs", 32'(hs_log[4]), 32'(t + 6));
    check("t1_done_cycle", 32'(done_log[0]), 32'(t + 7));
    check("t1_pops", 32'(pop_cnt - base), 5);
    check("t1_fifo_empty", 32'(fifo_empty), 1);
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // ---------------- Back-pressure for 4 cycles ----------------
    clear_logs();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_push(W'(8'h10 + i));
    for (int i = 0; i < 5; i++) push_exp(W'(8'h10 + i), i == 4);
    base = pop_cnt;
    do_req(5, t);
    step();  // cycle T+2
    @(negedge clk);
    check("t2_valid_first", 32'(out_valid), 1);
    check("t2_data_first", 32'(out_data), 32'h10);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("t2_stall_data", 32'(out_data), 32'h10);
      check("t2_stall_nopop", 32'(fifo_pop), 0);
    end
    check("t2_pops_stalled", 32'(pop_cnt - base), 2);
    step();
    out_ready = 1'b1;
    wait_done(1, 50);
    check("t2_hs_count", 32'(hs_log.size()), 5);
    check("t2_pops", 32'(pop_cnt - base), 5);
    check("t2_sb_empty", 32'(exp_q.size()), 0);

    // ---------------- Empty fifo, words trickle in ----------------
    clear_logs();
    step();
    for (int i = 0; i < 3; i++) push_exp(W'(8'hA1 + i), i == 2);
    base = pop_cnt;
    do_req(3, t);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_idle_valid", 32'(out_valid), 0);
      check("t3_idle_pop", 32'(fifo_pop), 0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      fifo_push(W'(8'hA1 + k));
      @(negedge clk);
      check("t3_pop_now", 32'(fifo_pop), 1);
      step();
      @(negedge clk);
      check("t3_word_valid", 32'(out_valid), 1);
      check("t3_word_data", 32'(out_data), 32'(8'hA1 + k));
      step();
      step();
    end
    wait_done(1, 20);
    check("t3_hs_count", 32'(hs_log.size()), 3);
    check("t3_done_after_last", 32'(done_log[0]), 32'(hs_log[2] + 1));
    check("t3_pops", 32'(pop_cnt - base), 3);

    // ---------------- Zero-length request ----------------
    clear_logs();
    step();
    fifo_push(8'h55);
    base = pop_cnt;
    do_req(0, t);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 1);
    check("t4_no_pop", 32'(fifo_pop), 0);
    check("t4_no_valid", 32'(out_valid), 0);
    check("t4_req_ready", 32'(req_ready), 1);
    step();
    @(negedge clk);
    check("t4_done_low", 32'(done), 0);
    check("t4_no_pop2", 32'(fifo_pop), 0);
    check("t4_no_valid2", 32'(out_valid), 0);
    check("t4_pops", 32'(pop_cnt - base), 0);
    check("t4_done_count", 32'(done_log.size()), 1);
    step();
    fifo_flush();

    // ---------------- Asynchronous reset mid-request ----------------
    clear_logs();
    for (int i = 0; i < 8; i++) fifo_push(W'(8'h20 + i));
    for (int i = 0; i < 8; i++) push_exp(W'(8'h20 + i), i == 7);
    do_req(8, t);
    b = 30;
    while (hs_log.size() < 3 && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check("t5_hs_timeout", 32'(hs_log.size() >= 3), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_pop", 32'(fifo_pop), 0);
    check("t5_rst_done", 32'(done), 0);
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_req_ready", 32'(req_ready), 1);
    clear_logs();
    base = pop_cnt;
    r = frd;
    push_exp(fmem[r[5:0]], 1'b0);
    r = r + 1;
    push_exp(fmem[r[5:0]], 1'b1);
    do_req(2, t);
    wait_done(1, 30);
    check("t5_hs_count", 32'(hs_log.size()), 2);
    check("t5_pops", 32'(pop_cnt - base), 2);
    check("t5_sb_empty", 32'(exp_q.size()), 0);
    step();
    fifo_flush();

    // ---------------- Back-to-back requests of 2 and 3 ----------------
    clear_logs();
    for (int i = 0; i < 5; i++) fifo_push(W'(8'h30 + i));
    for (int i = 0; i < 5; i++) push_exp(W'(8'h30 + i), (i == 1) || (i == 4));
    base = pop_cnt;
    do_req(2, t);
    do_req(3, t2);
    wait_done(2, 60);
    check("t6_done_count", 32'(done_log.size()), 2);
    check("t6_hs_count", 32'(hs_log.size()), 5);
    check("t6_gap", 32'(t2), 32'(done_log[0]));
    check("t6_pops", 32'(pop_cnt - base), 5);
    check("t6_fifo_empty", 32'(fifo_empty), 1);
    check("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
